dvp_transmit: RTL and testbench

//  DVP source: emits OV5640-style parallel video (vsync, href, 8-bit data) on pclk.

---
 rtl/dvp_transmit_if.sv | 25 ++
 rtl/dvp_transmit.sv | 185 ++++++++++++++++++
 tb/tb_dvp_transmit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_transmit_if.sv
// Bundle for the DVP transmitter: pixel stream in, parallel video out.
// The DVP source (master) drives the video side and pix_ready.
interface dvp_transmit_if;
    logic        en;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic [11:0] xaddr;
    logic [11:0] yaddr;
    logic        underflow;
    logic        frame_done;

    modport master (
        input  en, pix_data, pix_valid,
        output pix_ready, vsync, href, data, xaddr, yaddr, underflow, frame_done
    );

    modport slave (
        output en, pix_data, pix_valid,
        input  pix_ready, vsync, href, data, xaddr, yaddr, underflow, frame_done
    );
endinterface

// File: rtl/dvp_transmit.sv
// OV5640-style DVP source: sends RGB565 pixels as two bytes (high first)
// inside parameterised vsync/href frame timing, repeating while en is high.
module dvp_transmit #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int VS_CYC   = 1000,
    parameter int VBP_CYC  = 2000,
    parameter int VFP_CYC  = 500
) (
    input  logic           pclk,
    input  logic           rst,
    dvp_transmit_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        HBLANK,
        VFRONT
    } state_t;

    localparam logic [11:0] H_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [15:0] VS_LAST  = 16'(VS_CYC - 1);
    localparam logic [15:0] VBP_LAST = 16'(VBP_CYC - 1);
    localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
    localparam logic [15:0] VFP_LAST = 16'(VFP_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] x_q, x_d;
    logic        phase_q, phase_d;
    logic [7:0]  hold_q, hold_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  data_q, data_d;
    logic [11:0] xaddr_q, xaddr_d;
    logic [11:0] yaddr_q, yaddr_d;
    logic        underflow_q, underflow_d;
    logic        frame_done_q, frame_done_d;

    // The state register leads the video outputs by one cycle, so the
    // outputs below are decoded from state_q and registered together.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        phase_d      = phase_q;
        hold_d       = hold_q;
        vsync_d      = 1'b0;
        href_d       = 1'b0;
        data_d       = 8'h00;
        xaddr_d      = 12'd0;
        yaddr_d      = yaddr_q;
        underflow_d  = underflow_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d   = 16'd0;
                yaddr_d = 12'd0;
                if (bus.en) state_d = VSYNC;
            end

            VSYNC: begin
                vsync_d = 1'b1;
                if (cnt_q == 16'd0) begin
                    underflow_d = 1'b0;
                    yaddr_d     = 12'd0;
                end
                if (cnt_q == VS_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = VBACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            VBACK: begin
                if (cnt_q == VBP_LAST) begin
                    cnt_d   = 16'd0;
                    x_d     = 12'd0;
                    phase_d = 1'b0;
                    state_d = ACTIVE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ACTIVE: begin
                href_d  = 1'b1;
                xaddr_d = x_q;
                phase_d = ~phase_q;
                if (!phase_q) begin
                    // A missing pixel still occupies its two byte slots as zeros.
                    if (bus.pix_valid) begin
                        data_d = bus.pix_data[15:8];
                        hold_d = bus.pix_data[7:0];
                    end else begin
                        data_d      = 8'h00;
                        hold_d      = 8'h00;
                        underflow_d = 1'b1;
                    end
                end else begin
                    data_d = hold_q;
                    if (x_q == H_LAST) begin
                        x_d     = 12'd0;
                        cnt_d   = 16'd0;
                        state_d = (yaddr_q == V_LAST) ? VFRONT : HBLANK;
                    end else begin
                        x_d = x_q + 12'd1;
                    end
                end
            end

            HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d   = 16'd0;
                    phase_d = 1'b0;
                    yaddr_d = yaddr_q + 12'd1;
                    state_d = ACTIVE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            VFRONT: begin
                if (cnt_q == VFP_LAST) begin
                    cnt_d        = 16'd0;
                    frame_done_d = 1'b1;
                    state_d      = bus.en ? VSYNC : IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            x_q          <= 12'd0;
            phase_q      <= 1'b0;
            hold_q       <= 8'h00;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            xaddr_q      <= 12'd0;
            yaddr_q      <= 12'd0;
            underflow_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            phase_q      <= phase_d;
            hold_q       <= hold_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            xaddr_q      <= xaddr_d;
            yaddr_q      <= yaddr_d;
            underflow_q  <= underflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_ready  = (state_q == ACTIVE) && !phase_q;
    assign bus.vsync      = vsync_q;
    assign bus.href       = href_q;
    assign bus.data       = data_q;
    assign bus.xaddr      = xaddr_q;
    assign bus.yaddr      = yaddr_q;
    assign bus.underflow  = underflow_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_dvp_transmit.sv
// Bench for dvp_transmit: a frame-position model derived from the timing
// parameters predicts every output cycle while randomized pixels are offered.
module tb_dvp_transmit;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int HB   = 3;
    localparam int VS   = 2;
    localparam int VBP  = 3;
    localparam int VFP  = 2;
    localparam int LINE = 2 * H + HB;
    localparam int A    = VS + VBP;
    localparam int P    = A + V * LINE - HB + VFP;

    logic pclk = 1'b0;
    logic rst;
    dvp_transmit_if bus ();

    dvp_transmit #(
        .H_ACTIVE (H),
        .H_BLANK  (HB),
        .V_ACTIVE (V),
        .VS_CYC   (VS),
        .VBP_CYC  (VBP),
        .VFP_CYC  (VFP)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model state: m_pos is the output-cycle position in the frame, -1 when idle.
    int          m_pos     = -1;
    bit          en_e1     = 1'b0;
    logic [7:0]  slot_lo   = 8'h00;
    logic        exp_uf    = 1'b0;
    int          ready_cnt = 0;
    int          vs_len    = 0;
    int          mode      = 0;
    logic [15:0] cur_pix   = 16'hA1B2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int pos, input bit e);
        if (pos < 0 || pos == P - 1) return e ? 0 : -1;
        return pos + 1;
    endfunction

    function automatic bit href_at(input int pos);
        int q;
        if (pos < A) return 1'b0;
        q = pos - A;
        if (q >= V * LINE - HB) return 1'b0;
        return (q % LINE) < 2 * H;
    endfunction

    function automatic int byte_of(input int pos);
        return (pos - A) % LINE;
    endfunction

    function automatic int line_of(input int pos);
        return (pos - A) / LINE;
    endfunction

    // One cycle: advance model, compare outputs at negedge, drive next inputs.
    task automatic step();
        logic       exp_vs, exp_hr, exp_fd, exp_rdy, nv;
        logic [7:0] exp_data;
        int         b, np;
        bit         accepted;
        @(negedge pclk);
        m_pos   = nxt(m_pos, en_e1);
        en_e1   = bus.en;
        exp_vs  = (m_pos >= 0) && (m_pos < VS);
        exp_hr  = href_at(m_pos);
        exp_fd  = (m_pos == P - 1);
        exp_data = 8'h00;
        accepted = 1'b0;
        if (m_pos == 0) exp_uf = 1'b0;
        if (exp_hr) begin
            b = byte_of(m_pos);
            if (b % 2 == 0) begin
                if (bus.pix_valid) begin
                    exp_data = bus.pix_data[15:8];
                    slot_lo  = bus.pix_data[7:0];
                    accepted = 1'b1;
                end else begin
                    slot_lo = 8'h00;
                    exp_uf  = 1'b1;
                end
            end else begin
                exp_data = slot_lo;
            end
        end
        chk("vsync", 32'(bus.vsync), 32'(exp_vs));
        chk("href", 32'(bus.href), 32'(exp_hr));
        chk("data", 32'(bus.data), 32'(exp_data));
        chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
        chk("underflow", 32'(bus.underflow), 32'(exp_uf));
        if (exp_hr) begin
            chk("xaddr", 32'(bus.xaddr), 32'(byte_of(m_pos) / 2));
            chk("yaddr", 32'(bus.yaddr), 32'(line_of(m_pos)));
        end else if (m_pos < 0) begin
            chk("yaddr_idle", 32'(bus.yaddr), 32'd0);
        end
        np      = nxt(m_pos, bus.en);
        exp_rdy = href_at(np) && (byte_of(np) % 2 == 0);
        chk("pix_ready", 32'(bus.pix_ready), 32'(exp_rdy));

        if (bus.pix_ready) ready_cnt++;
        if (exp_fd) begin
            chk("handshakes_per_frame", 32'(ready_cnt), 32'(H * V));
            ready_cnt = 0;
        end
        if (bus.vsync) vs_len++;
        else if (vs_len > 0) begin
            chk("vsync_width", 32'(vs_len), 32'(VS));
            vs_len = 0;
        end

        if (accepted) cur_pix = (mode == 0) ? {cur_pix[15:8] + 8'h22, cur_pix[7:0] + 8'h22}
                                            : 16'($urandom);
        if (exp_rdy) begin
            case (mode)
                0:       nv = 1'b1;
                1:       nv = ($urandom_range(3) != 0);
                default: nv = !(line_of(np) == 0 && byte_of(np) == 2);
            endcase
        end else begin
            nv = 1'($urandom_range(1));
        end
        bus.pix_valid = nv;
        bus.pix_data  = (nv && exp_rdy) ? cur_pix : 16'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic restart_model();
        m_pos     = -1;
        en_e1     = 1'b0;
        exp_uf    = 1'b0;
        ready_cnt = 0;
        vs_len    = 0;
    endtask

    initial begin
        int guard;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 16'h0000;
        #1;
        chk("rst_vsync", 32'(bus.vsync), 32'd0);
        chk("rst_href", 32'(bus.href), 32'd0);
        chk("rst_data", 32'(bus.data), 32'd0);
        chk("rst_xaddr", 32'(bus.xaddr), 32'd0);
        chk("rst_yaddr", 32'(bus.yaddr), 32'd0);
        chk("rst_underflow", 32'(bus.underflow), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        restart_model();
        run(3);

        // Directed frame with sequential pixels A1B2, C3D4, ...
        bus.en = 1'b1;
        mode   = 0;
        run(P + 2);

        // Second pixel of line 0 missing.
        mode = 2;
        run(P);

        // Randomized valid pattern across several frames.
        mode = 1;
        run(4 * P);

        // Drop en during line 1: the frame completes, then idle.
        guard = 0;
        while (!(bus.href && bus.yaddr == 12'd1) && guard < 4 * P) begin
            step();
            guard++;
        end
        chk("reach_line1", 32'(guard < 4 * P), 32'd1);
        bus.en = 1'b0;
        run(P + 4);

        // Reset while href is high, then restart with en held high.
        bus.en = 1'b1;
        guard  = 0;
        while (!bus.href && guard < 4 * P) begin
            step();
            guard++;
        end
        chk("reach_active", 32'(guard < 4 * P), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_href", 32'(bus.href), 32'd0);
        chk("midrst_vsync", 32'(bus.vsync), 32'd0);
        chk("midrst_data", 32'(bus.data), 32'd0);
        chk("midrst_pix_ready", 32'(bus.pix_ready), 32'd0);
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        restart_model();
        run(2 * P + 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
